// File: rtl/hls_phi_loop_unit.sv
// hls_phi_loop_unit: phi/add/branch loop counter emitting one value per iteration
module hls_phi_loop_unit #(
    parameter int WIDTH    = 8,
    parameter int BB_WIDTH = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [WIDTH-1:0]    init,
    input  logic [WIDTH-1:0]    step,
    input  logic [WIDTH-1:0]    bound,
    input  logic                ready,
    output logic [WIDTH-1:0]    value,
    output logic                value_valid,
    output logic [BB_WIDTH-1:0] last_block,
    output logic                busy,
    output logic                done
);
    typedef enum logic [1:0] {IDLE, RUN, CHECK, DONE} state_t;
    state_t state, state_nx;
    logic [WIDTH-1:0] init_r, step_r, bound_r, acc, phi_out, sum;
    logic cont, load, adv;
    // phi picks the incoming value of the predecessor block; unknown block yields 0
    always_comb begin
        phi_out = (last_block == BB_WIDTH'(0)) ? init_r :
                  (last_block == BB_WIDTH'(1)) ? acc : '0;
    end
    assign sum  = phi_out + step_r;
    assign cont = $signed(acc) < $signed(bound_r);
    assign load = start && (state == IDLE || state == DONE);
    assign adv  = (state == RUN) && ready;
    // next state and status outputs
    always_comb begin
        state_nx = IDLE;
        busy     = (state == RUN) || (state == CHECK);
        done     = (state == DONE);
        case (state)
            IDLE:    state_nx = load ? RUN : IDLE;
            RUN:     state_nx = adv ? CHECK : RUN;
            CHECK:   state_nx = cont ? RUN : DONE;
            DONE:    state_nx = load ? RUN : DONE;
            default: state_nx = IDLE;
        endcase
    end
    // state, operand capture and iteration datapath registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            init_r      <= '0;
            step_r      <= '0;
            bound_r     <= '0;
            acc         <= '0;
            value       <= '0;
            value_valid <= 1'b0;
            last_block  <= '0;
        end else begin
            state       <= state_nx;
            value_valid <= adv;
            if (load) begin
                init_r     <= init;
                step_r     <= step;
                bound_r    <= bound;
                last_block <= '0;
            end
            if (adv) begin
                acc        <= sum;
                value      <= sum;
                last_block <= BB_WIDTH'(1);
            end
        end
    end
endmodule

// File: tb/tb_hls_phi_loop_unit.sv
// tb_hls_phi_loop_unit: directed-vector bench for hls_phi_loop_unit
module tb_hls_phi_loop_unit;
    logic        clk, rst, start, ready;
    logic [7:0]  init, step, bound, value;
    logic        value_valid, busy, done;
    logic [31:0] last_block;
    int          errors = 0;
    int          checks = 0;

    hls_phi_loop_unit #(.WIDTH(8), .BB_WIDTH(32)) dut (
        .clk(clk), .rst(rst), .start(start), .init(init), .step(step),
        .bound(bound), .ready(ready), .value(value), .value_valid(value_valid),
        .last_block(last_block), .busy(busy), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic do_start(input logic [7:0] i, input logic [7:0] s, input logic [7:0] b);
        @(negedge clk);
        start = 1'b1; init = i; step = s; bound = b;
        @(negedge clk);
        start = 1'b0; init = 8'h55; step = 8'h55; bound = 8'h55;
    endtask

    task automatic wait_pulse(input string tag, input logic [7:0] exp_v, input int exp_d);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!value_valid && n < 20);
        check({tag, "_dly"}, n, exp_d);
        check({tag, "_val"}, value, exp_v);
    endtask

    task automatic expect_done(input string tag, input logic [7:0] exp_v);
        @(negedge clk);
        check({tag, "_done"}, done, 1);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_final"}, value, exp_v);
        check({tag, "_lb"}, last_block, 1);
    endtask

    initial begin
        int pulses;
        rst = 1'b0; start = 1'b0; ready = 1'b1; init = '0; step = '0; bound = '0;
        repeat (2) @(negedge clk);
        check("rst_value", value, 0);
        check("rst_valid", value_valid, 0);
        check("rst_lb", last_block, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        rst = 1'b1;
        @(negedge clk);
        check("idle_busy", busy, 0);

        do_start(8'd0, 8'd1, 8'd3);
        check("t1_lb0", last_block, 0);
        check("t1_busy", busy, 1);
        wait_pulse("t1_p1", 8'd1, 1);
        wait_pulse("t1_p2", 8'd2, 2);
        wait_pulse("t1_p3", 8'd3, 2);
        expect_done("t1", 8'd3);

        ready = 1'b0;
        do_start(8'd0, 8'd1, 8'd3);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("t2_stall_valid", value_valid, 0);
            check("t2_stall_value", value, 3);
            check("t2_stall_busy", busy, 1);
            check("t2_stall_lb", last_block, 0);
        end
        ready = 1'b1;
        wait_pulse("t2_p1", 8'd1, 1);
        wait_pulse("t2_p2", 8'd2, 2);
        wait_pulse("t2_p3", 8'd3, 2);
        expect_done("t2", 8'd3);

        do_start(8'd0, 8'd1, 8'hFF);
        wait_pulse("t3_p1", 8'd1, 1);
        expect_done("t3", 8'd1);

        do_start(8'h7E, 8'd1, 8'h7F);
        wait_pulse("t4a_p1", 8'h7F, 1);
        expect_done("t4a", 8'h7F);

        do_start(8'h7F, 8'd1, 8'h00);
        for (int k = 0; k < 129; k++) wait_pulse("t4b", 8'(8'h80 + k), (k == 0) ? 1 : 2);
        expect_done("t4b", 8'h00);

        do_start(8'd5, 8'd2, 8'd9);
        check("t5_lb0", last_block, 0);
        wait_pulse("t5_p1", 8'd7, 1);
        wait_pulse("t5_p2", 8'd9, 2);
        expect_done("t5", 8'd9);

        do_start(8'd0, 8'd1, 8'd3);
        wait_pulse("t6_p1", 8'd1, 1);
        #2 rst = 1'b0;
        #1;
        check("t6_value", value, 0);
        check("t6_valid", value_valid, 0);
        check("t6_lb", last_block, 0);
        check("t6_busy", busy, 0);
        check("t6_done", done, 0);
        @(negedge clk);
        rst = 1'b1;
        pulses = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (value_valid) pulses++;
        end
        check("t6_no_pulse", pulses, 0);
        check("t6_idle_busy", busy, 0);
        do_start(8'd0, 8'd1, 8'd1);
        wait_pulse("t6_p_after", 8'd1, 1);
        expect_done("t6", 8'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
